store_buffer: RTL and testbench

//   Write-side counterpart of the load alignment path. Accepts stores from the MEM stage and

---
 rtl/mach_v_pkg.sv | 32 +++
 rtl/store_align.sv | 43 ++++
 rtl/store_buffer.sv | 112 +++++++++++
 tb/tb_store_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mach_v_pkg.sv
// Shared core definitions: funct3 encodings for loads/stores and the store-buffer entry layout.
package mach_v_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int BE_W = 4;

  typedef struct packed {
    logic [29:0]     waddr;
    logic [31:0]     data;
    logic [BE_W-1:0] be;
  } store_entry_t;

  localparam int STORE_ENTRY_W = $bits(store_entry_t);

  function automatic logic [31:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [31:0] mask;
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane alignment: places SB/SH/SW data on the addressed byte lanes and flags illegal stores.
module store_align
  import mach_v_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [31:0]     wdata,
  output logic [31:0]     data,
  output logic [BE_W-1:0] be,
  output logic            misaligned
);

  // Lane shift and byte-enable generation; rejected stores leave data/be at zero.
  always_comb begin
    data       = 32'h0000_0000;
    be         = 4'b0000;
    misaligned = 1'b0;
    case (funct3)
      F3_SB: begin
        be   = 4'b0001 << off;
        data = {4{wdata[7:0]}} & be_to_mask(be);
      end
      F3_SH: begin
        if (off[0]) begin
          misaligned = 1'b1;
        end else begin
          be   = 4'b0011 << off;
          data = {16'h0000, wdata[15:0]} << {off, 3'b000};
        end
      end
      F3_SW: begin
        if (off != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          be   = 4'b1111;
          data = wdata;
        end
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between MEM stage and data memory, with misalignment rejection
// and a word-address hazard against the load currently in MEM.
module store_buffer
  import mach_v_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        StoreValid,
  output logic        StoreReady,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] StoreAddr,
  input  logic [31:0] WriteData_in,
  output logic        StoreMisaligned,
  output logic        MemWrite,
  input  logic        MemReady,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] LoadAddr,
  output logic        LoadHazard,
  output logic        Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [DEPTH-1:0] valid_r;
  logic             misaligned_r;
  store_entry_t     entries_r [DEPTH];

  logic [31:0]      align_data_s;
  logic [BE_W-1:0]  align_be_s;
  logic             align_mis_s;
  logic             full_s;
  logic             accept_s;
  logic             enq_s;
  logic             deq_s;
  logic             hazard_s;
  store_entry_t     head_s;

  store_align u_align (
    .funct3     (Funct3M),
    .off        (StoreAddr[1:0]),
    .wdata      (WriteData_in),
    .data       (align_data_s),
    .be         (align_be_s),
    .misaligned (align_mis_s)
  );

  // Ready looks only at the registered count, so a full buffer refuses even when memory drains.
  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign StoreReady = RESETn & ~full_s;
  assign accept_s   = StoreValid & StoreReady;
  assign enq_s      = accept_s & ~align_mis_s;
  assign deq_s      = MemWrite & MemReady;

  assign head_s          = entries_r[head_r];
  assign MemWrite        = (count_r != {CNT_W{1'b0}});
  assign Empty           = ~MemWrite;
  assign MemAddr         = MemWrite ? {head_s.waddr, 2'b00} : 32'h0000_0000;
  assign MemWriteData    = MemWrite ? head_s.data : 32'h0000_0000;
  assign MemByteEn       = MemWrite ? head_s.be : 4'b0000;
  assign StoreMisaligned = misaligned_r;
  assign LoadHazard      = hazard_s;

  // Pointer, occupancy and misalignment-pulse state.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      valid_r      <= {DEPTH{1'b0}};
      misaligned_r <= 1'b0;
    end else begin
      misaligned_r <= accept_s & align_mis_s;
      if (enq_s) begin
        tail_r          <= tail_r + PTR_W'(1);
        valid_r[tail_r] <= 1'b1;
      end
      if (deq_s) begin
        head_r          <= head_r + PTR_W'(1);
        valid_r[head_r] <= 1'b0;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (enq_s) begin
      entries_r[tail_r] <= '{waddr: StoreAddr[31:2], data: align_data_s, be: align_be_s};
    end
  end

  // Word-address match against every valid entry, including a head that retires this cycle.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_s = hazard_s | (valid_r[i] & ({entries_r[i].waddr, LoadAddr[1:0]} == LoadAddr));
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios plus randomized traffic vs a byte-level model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RESETn;
  logic        StoreValid;
  logic        StoreReady;
  logic [2:0]  Funct3M;
  logic [31:0] StoreAddr;
  logic [31:0] WriteData_in;
  logic        StoreMisaligned;
  logic        MemWrite;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [3:0]  MemByteEn;
  logic [31:0] LoadAddr;
  logic        LoadHazard;
  logic        Empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .StoreValid(StoreValid), .StoreReady(StoreReady),
    .Funct3M(Funct3M), .StoreAddr(StoreAddr), .WriteData_in(WriteData_in),
    .StoreMisaligned(StoreMisaligned), .MemWrite(MemWrite), .MemReady(MemReady),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemByteEn(MemByteEn),
    .LoadAddr(LoadAddr), .LoadHazard(LoadHazard), .Empty(Empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_mis = 1'b0;
  bit   rand_mode = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a store of n bytes is legal when the byte offset is a multiple of n;
  // byte b of rs2 lands on lane off+b.
  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                    output bit ok, output logic [31:0] data, output logic [3:0] be);
    int off = int'(a % 32'd4);
    int nbytes;
    case (f3)
      3'd0:    nbytes = 1;
      3'd1:    nbytes = 2;
      3'd2:    nbytes = 4;
      default: nbytes = 0;
    endcase
    ok   = (nbytes != 0) && (off % nbytes == 0);
    data = 32'h0;
    be   = 4'h0;
    if (ok) begin
      for (int b = 0; b < nbytes; b++) begin
        be[off+b] = 1'b1;
        data[8*(off+b) +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  // Monitor: checks all outputs mid-cycle against the model, then applies the coming edge to the model.
  always @(negedge CLK) begin
    bit          model_ready;
    bit          hz;
    bit          ok;
    logic [31:0] d;
    logic [3:0]  be;
    exp_t        e;
    model_ready = RESETn && (sbq.size() < DEPTH);
    cmp("store_ready", {31'd0, StoreReady}, {31'd0, model_ready});
    cmp("mem_write", {31'd0, MemWrite}, {31'd0, sbq.size() != 0});
    cmp("empty", {31'd0, Empty}, {31'd0, sbq.size() == 0});
    cmp("misaligned", {31'd0, StoreMisaligned}, {31'd0, exp_mis});
    hz = 1'b0;
    foreach (sbq[i]) if (sbq[i].addr[31:2] == LoadAddr[31:2]) hz = 1'b1;
    cmp("load_hazard", {31'd0, LoadHazard}, {31'd0, hz});
    if (MemWrite && MemReady) begin
      if (sbq.size() == 0) begin
        cmp("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        cmp("mem_addr", MemAddr, e.addr);
        cmp("mem_data", MemWriteData, e.data);
        cmp("mem_be", {28'd0, MemByteEn}, {28'd0, e.be});
      end
    end
    if (!RESETn) begin
      sbq.delete();
      exp_mis = 1'b0;
    end else if (StoreValid && model_ready) begin
      ref_store(Funct3M, StoreAddr, WriteData_in, ok, d, be);
      if (ok) sbq.push_back('{addr: {StoreAddr[31:2], 2'b00}, data: d, be: be});
      exp_mis = !ok;
    end else begin
      exp_mis = 1'b0;
    end
  end

  // Random MemReady and LoadAddr during the randomized phase; loads often target pending words.
  always @(posedge CLK) begin
    if (rand_mode) begin
      #1;
      MemReady = 1'($urandom_range(0, 1));
      if (sbq.size() > 0 && $urandom_range(0, 1) == 1)
        LoadAddr = sbq[$urandom_range(0, sbq.size() - 1)].addr + 32'($urandom_range(0, 3));
      else
        LoadAddr = 32'h5000 + 32'($urandom_range(0, 63));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    StoreValid   = 1'b1;
    Funct3M      = f3;
    StoreAddr    = a;
    WriteData_in = d;
    @(negedge CLK);
    while (!StoreReady && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (!StoreReady) cmp("send_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    StoreValid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge CLK);
    while (!Empty && n < 300) begin
      n++;
      @(negedge CLK);
    end
    cmp("drain_timeout", {31'd0, Empty}, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESETn = 1'b0; StoreValid = 1'b0; Funct3M = 3'd0; StoreAddr = 32'h0;
    WriteData_in = 32'h0; MemReady = 1'b1; LoadAddr = 32'hFFFF_FFF0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    cmp("rst_ready", {31'd0, StoreReady}, 32'd0);
    cmp("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    cmp("rst_empty", {31'd0, Empty}, 32'd1);
    cmp("rst_mis", {31'd0, StoreMisaligned}, 32'd0);
    cmp("rst_addr", MemAddr, 32'h0);
    cmp("rst_be", {28'd0, MemByteEn}, 32'd0);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // SB to the top lane, visible the cycle after acceptance
    send(3'b000, 32'h1003, 32'h0000_00A5);
    @(negedge CLK);
    cmp("sb_write", {31'd0, MemWrite}, 32'd1);
    cmp("sb_addr", MemAddr, 32'h1000);
    cmp("sb_data", MemWriteData, 32'hA500_0000);
    cmp("sb_be", {28'd0, MemByteEn}, 32'h8);
    @(posedge CLK); #1;

    send(3'b001, 32'h2002, 32'hDEAD_1234);
    @(negedge CLK);
    cmp("sh_data", MemWriteData, 32'h1234_0000);
    cmp("sh_be", {28'd0, MemByteEn}, 32'hC);
    @(posedge CLK); #1;
    send(3'b010, 32'h2004, 32'hDEAD_1234);
    @(negedge CLK);
    cmp("sw_addr", MemAddr, 32'h2004);
    cmp("sw_data", MemWriteData, 32'hDEAD_1234);
    cmp("sw_be", {28'd0, MemByteEn}, 32'hF);
    @(posedge CLK); #1;
    wait_empty();

    // Misaligned SW and SH: single pulse each, nothing enqueued
    send(3'b010, 32'h3001, 32'h1111_1111);
    @(negedge CLK);
    cmp("mis_sw", {31'd0, StoreMisaligned}, 32'd1);
    cmp("mis_sw_empty", {31'd0, Empty}, 32'd1);
    cmp("mis_sw_nowrite", {31'd0, MemWrite}, 32'd0);
    @(posedge CLK); #1;
    send(3'b001, 32'h3003, 32'h2222_2222);
    @(negedge CLK);
    cmp("mis_sh", {31'd0, StoreMisaligned}, 32'd1);
    cmp("mis_sh_empty", {31'd0, Empty}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    cmp("mis_single_pulse", {31'd0, StoreMisaligned}, 32'd0);
    @(posedge CLK); #1;

    // Fill with memory stalled, then drain in order
    MemReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(3'b010, 32'h6000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    @(negedge CLK);
    cmp("full_not_ready", {31'd0, StoreReady}, 32'd0);
    @(posedge CLK); #1;
    MemReady = 1'b1;
    @(negedge CLK);
    cmp("full_ready_held", {31'd0, StoreReady}, 32'd0);
    @(negedge CLK);
    cmp("ready_after_retire", {31'd0, StoreReady}, 32'd1);
    @(posedge CLK); #1;
    wait_empty();

    // Word-granular load hazard
    MemReady = 1'b0;
    send(3'b010, 32'h4008, 32'h5555_AAAA);
    LoadAddr = 32'h400B;
    @(negedge CLK);
    cmp("hazard_hit", {31'd0, LoadHazard}, 32'd1);
    #1 LoadAddr = 32'h400C;
    #1 cmp("hazard_next_word", {31'd0, LoadHazard}, 32'd0);
    @(posedge CLK); #1;
    LoadAddr = 32'h400B;
    MemReady = 1'b1;
    wait_empty();
    #1 cmp("hazard_after_retire", {31'd0, LoadHazard}, 32'd0);

    // Randomized traffic with random memory backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      logic [2:0] f3;
      if (r < 3) f3 = 3'b000;
      else if (r < 6) f3 = 3'b001;
      else if (r < 9) f3 = 3'b010;
      else f3 = 3'($urandom_range(3, 7));
      send(f3, 32'h5000 + 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end
    rand_mode = 1'b0;
    @(posedge CLK); #2;
    MemReady = 1'b1;
    wait_empty();

    // Reset in the middle of a drain discards everything
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) send(3'b010, 32'h7000 + 32'(4 * i), $urandom);
    MemReady = 1'b1;
    RESETn   = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    cmp("mid_reset_memwrite", {31'd0, MemWrite}, 32'd0);
    cmp("mid_reset_empty", {31'd0, Empty}, 32'd1);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    cmp("post_reset_empty", {31'd0, Empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
